// File: rtl/branch_pkg.sv
// Shared types for the branch target buffer: 2-bit direction counter,
// table entry layout and the saturating counter step.
package branch_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_e;

  // Tag is kept full-width and holds pc >> (IDX_W+2); upper bits are simply zero.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
    bp_ctr_e         ctr;
  } btb_entry_t;

  function automatic bp_ctr_e ctr_next(bp_ctr_e ctr, logic taken);
    bp_ctr_e nxt;
    nxt = ctr;
    if (taken && ctr != ST) begin
      nxt = bp_ctr_e'(ctr + 2'd1);
    end else if (!taken && ctr != SNT) begin
      nxt = bp_ctr_e'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches: mispredict detection, registered redirect pulse
// and branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int PC_W = branch_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  logic            mispredict_now;
  logic [PC_W-1:0] correct_pc;

  // A taken branch with the right direction can still mispredict on target.
  assign mispredict_now = ex_valid &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_target)));
  assign correct_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= mispredict_now;
      if (mispredict_now) begin
        redirect_pc <= correct_pc;
      end
      if (ex_valid) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict_now) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, flop-based branch target buffer with combinational fetch lookup
// and EX-side training; resolution and statistics live in branch_resolve_unit.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = branch_pkg::PC_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [PC_W-1:0] i_if_pc,
  output logic            o_if_hit,
  output logic            o_if_taken,
  output logic [PC_W-1:0] o_if_target,
  output logic [PC_W-1:0] o_if_next_pc,
  input  logic            i_ex_valid,
  input  logic [PC_W-1:0] i_ex_pc,
  input  logic            i_ex_taken,
  input  logic [PC_W-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [PC_W-1:0] i_ex_pred_target,
  output logic            o_mispredict,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispred_cnt
);

  import branch_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t       entries_q [ENTRIES];
  btb_entry_t       if_entry;
  btb_entry_t       ex_entry;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [PC_W-1:0]  if_tag;
  logic [PC_W-1:0]  ex_tag;
  logic             ex_hit;

  assign if_idx   = i_if_pc[IDX_W+1:2];
  assign if_tag   = i_if_pc >> (IDX_W + 2);
  assign ex_idx   = i_ex_pc[IDX_W+1:2];
  assign ex_tag   = i_ex_pc >> (IDX_W + 2);
  assign if_entry = entries_q[if_idx];
  assign ex_entry = entries_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign o_if_hit     = if_entry.valid && (if_entry.tag == if_tag);
  assign o_if_taken   = o_if_hit && if_entry.ctr[1];
  assign o_if_target  = o_if_hit ? if_entry.target : '0;
  assign o_if_next_pc = o_if_taken ? if_entry.target : i_if_pc + PC_W'(4);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (i_ex_valid) begin
      if (ex_hit) begin
        entries_q[ex_idx].ctr <= ctr_next(ex_entry.ctr, i_ex_taken);
        if (i_ex_taken) begin
          entries_q[ex_idx].target <= i_ex_target;
        end
      end else if (i_ex_taken) begin
        // Taken misses claim the slot, evicting any alias; new entries start weak-taken.
        entries_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: i_ex_target, ctr: WT};
      end
    end
  end

  branch_resolve_unit #(
    .PC_W(PC_W)
  ) u_resolve (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .ex_valid       (i_ex_valid),
    .ex_pc          (i_ex_pc),
    .ex_taken       (i_ex_taken),
    .ex_target      (i_ex_target),
    .ex_pred_taken  (i_ex_pred_taken),
    .ex_pred_target (i_ex_pred_target),
    .mispredict     (o_mispredict),
    .redirect_pc    (o_redirect_pc),
    .branch_cnt     (o_branch_cnt),
    .mispred_cnt    (o_mispred_cnt)
  );

endmodule
